// File: rtl/upt_seq_pkg.sv
// Shared definitions for the UPT sequencer: state encoding, sample width and
// the per-state decode of the core control pins.
package upt_seq_pkg;

   localparam int SAMPLE_W = 64;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RESET   = 3'd1,
      S_SEED    = 3'd2,
      S_CALIB   = 3'd3,
      S_RUN     = 3'd4,
      S_READ    = 3'd5,
      S_RELEASE = 3'd6
   } state_t;

   typedef struct packed {
      logic rst;
      logic init;
      logic calib;
      logic en;
      logic read;
   } core_ctl_t;

   function automatic core_ctl_t core_ctl(input state_t s);
      core_ctl_t c;
      c = '0;
      case (s)
         S_IDLE, S_RESET:   c.rst   = 1'b1;
         S_SEED:            c.init  = 1'b1;
         S_CALIB:           c.calib = 1'b1;
         S_RUN, S_RELEASE:  c.en    = 1'b1;
         S_READ: begin
            c.en   = 1'b1;
            c.read = 1'b1;
         end
         default:           c.rst   = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/upt_seq_fifo.sv
// First-word-fall-through synchronous FIFO holding UPT samples.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module upt_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_pop;
   logic             w_push;

   assign w_pop  = pop && (r_level != '0);
   assign w_push = push && ((r_level != LW'(DEPTH)) || w_pop);

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= push_data;
   end

   assign rd_data = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
   assign level   = r_level;
   assign full    = (r_level == LW'(DEPTH));
   assign empty   = (r_level == '0);

endmodule

// File: rtl/upt_seq_ctrl.sv
// UPT entropy-core sequencer: bring-up (reset, seed, calibrate) then read loop into a FIFO.
// Define UPT_SEQ_TIMEOUT_EN to enable the READ-state watchdog and timeout_err flag.
module upt_seq_ctrl
   import upt_seq_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int RST_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          stop,
   input  logic [31:0]                   cfg_calib_cycles,
   output logic                          core_rst,
   output logic                          core_init,
   output logic                          core_calib,
   output logic                          core_en,
   output logic                          core_read,
   input  logic                          core_ready,
   input  logic [SAMPLE_W-1:0]           core_sample,
   output logic                          rd_valid,
   output logic [SAMPLE_W-1:0]           rd_data,
   input  logic                          rd_pop,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic [2:0]                    state_o,
   output logic                          timeout_err
);
`ifdef UPT_SEQ_TIMEOUT_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_cnt;
   logic [31:0] r_calib_ld;
   core_ctl_t   r_ctl;
   logic        w_push;
   logic        w_full;
   logic        w_empty;
   logic        w_wd_fire;
   logic        w_start_ok;

   // A capture in READ completes even if stop arrives in the same cycle.
   assign w_push     = (r_state == S_READ) && core_ready;
   assign w_wd_fire  = WD_EN && (r_state == S_READ) && !core_ready &&
                       (r_cnt == 32'(TIMEOUT_CYCLES - 1));
   assign w_start_ok = (r_state == S_IDLE) && (w_state_next == S_RESET);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_state_next = S_RESET;
         S_RESET:   if (r_cnt == 32'(RST_CYCLES - 1)) w_state_next = S_SEED;
         S_SEED:    w_state_next = (r_calib_ld == '0) ? S_RUN : S_CALIB;
         S_CALIB:   if (r_cnt == r_calib_ld - 32'd1) w_state_next = S_RUN;
         S_RUN:     if (!w_full) w_state_next = S_READ;
         S_READ: begin
            if (core_ready)     w_state_next = S_RELEASE;
            else if (w_wd_fire) w_state_next = S_RESET;
         end
         S_RELEASE: if (!core_ready) w_state_next = S_RUN;
         default:   w_state_next = S_IDLE;
      endcase
      if (stop) w_state_next = S_IDLE;
   end

   // Core pins are decoded from the next state so they change on state entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_ctl      <= core_ctl(S_IDLE);
         r_cnt      <= '0;
         r_calib_ld <= '0;
      end else begin
         r_state <= w_state_next;
         r_ctl   <= core_ctl(w_state_next);
         r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + 32'd1;
         if (w_start_ok) r_calib_ld <= cfg_calib_cycles;
      end
   end

`ifdef UPT_SEQ_TIMEOUT_EN
   logic r_timeout_err;
   always_ff @(posedge clk) begin
      if (!rst_n)                 r_timeout_err <= 1'b0;
      else if (w_start_ok)        r_timeout_err <= 1'b0;
      else if (w_wd_fire && !stop) r_timeout_err <= 1'b1;
   end
   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

   upt_seq_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (core_sample),
      .pop       (rd_pop),
      .rd_data   (rd_data),
      .level     (fifo_level),
      .full      (w_full),
      .empty     (w_empty)
   );

   assign core_rst   = r_ctl.rst;
   assign core_init  = r_ctl.init;
   assign core_calib = r_ctl.calib;
   assign core_en    = r_ctl.en;
   assign core_read  = r_ctl.read;
   assign rd_valid   = !w_empty;
   assign busy       = (r_state != S_IDLE);
   assign state_o    = r_state;

endmodule

// File: doc/upt_seq_ctrl.md
Name: upt_seq_ctrl

Overview:
- Hardware sequencer for the UPT TRNG/PUF entropy core.
- Runs the bring-up sequence: core reset, seed load, calibration, enable.
- Then repeatedly runs read handshakes and buffers 64-bit samples in a small FIFO, so software pops random words instead of toggling control bits.
- Sits between the peripheral register file and the UPT core control and readout pins.

Parameters:
- FIFO_DEPTH, 4, number of 64-bit sample entries; power of two, 2..16.
- RST_CYCLES, 4, cycles core_rst is held in the RESET state; at least 1.
- TIMEOUT_CYCLES, 1024, READ-state watchdog limit; only used with UPT_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse; starts the sequence from IDLE, ignored elsewhere
- stop  in  1  single-cycle pulse; returns to IDLE from any state
- cfg_calib_cycles  in  32  calibration length in clocks, sampled at start
- core_rst  out  1  UPT reset request
- core_init  out  1  UPT seed-load strobe
- core_calib  out  1  UPT calibration enable
- core_en  out  1  UPT generator enable
- core_read  out  1  UPT read request
- core_ready  in  1  UPT sample-ready flag
- core_sample  in  64  {sample_1, sample_0} from UPT
- rd_valid  out  1  FIFO non-empty
- rd_data  out  64  FIFO head entry
- rd_pop  in  1  consume head entry; ignored when rd_valid=0
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- busy  out  1  state != IDLE
- state_o  out  3  state encoding, for debug readback
- timeout_err  out  1  sticky watchdog flag; tied to 0 without the macro

Behaviour:
- Reset: clk and rst_n, synchronous active-low, as already decided. All outputs are 0 after reset except core_rst=1. State is IDLE, FIFO is empty, counters are 0.
- State encoding: IDLE=0, RESET=1, SEED=2, CALIB=3, RUN=4, READ=5, RELEASE=6.
- IDLE
  - core_rst=1, all other core outputs 0.
  - start moves to RESET and latches cfg_calib_cycles into calib_cnt_ld.
- RESET
  - core_rst=1 for exactly RST_CYCLES cycles, then go to SEED.
- SEED
  - core_init=1 for exactly 1 cycle, then go to CALIB.
- CALIB
  - core_calib=1.
  - Stay for calib_cnt_ld cycles, then go to RUN.
  - A value of 0 skips the state: core_calib is never asserted and the FSM moves from SEED directly to RUN.
- RUN
  - core_en=1.
  - If fifo_level < FIFO_DEPTH, go to READ on the next cycle; otherwise stay in RUN.
- READ
  - core_en=1, core_read=1.
  - When core_ready=1, core_sample is written to the FIFO in that same cycle and the FSM goes to RELEASE.
- RELEASE
  - core_en=1, core_read=0.
  - Wait until core_ready=0, then go to RUN.
- Core output timing: all core_* outputs are registered and decoded from the next state, so they take effect in the same cycle the state is entered.
- Stop
  - stop goes to IDLE from any state, with priority over every other transition.
  - FIFO contents are kept.
  - A captured write that coincides with stop still completes.
  - start and stop in the same cycle: stop wins.
- FIFO
  - First-word-fall-through: rd_data is valid whenever rd_valid=1.
  - A pop advances the read pointer; the new head is visible the next cycle.
  - Write and pop in the same cycle at level=FIFO_DEPTH: both occur and the level is unchanged. The FSM never writes when full, because READ is only entered when level < FIFO_DEPTH.
  - Pop while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - Level saturates by construction; overflow is impossible.
- rst_n low mid-operation: full return to the reset state within 1 cycle and the FIFO is flushed.

Optional Feature:
- Macro: UPT_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs while in READ.
  - When it reaches TIMEOUT_CYCLES without core_ready, timeout_err is set (sticky) and the FSM goes to RESET, re-running the init sequence; no FIFO write occurs.
  - timeout_err clears only on start or rst_n.
- Undefined:
  - No counter and no port logic; timeout_err is tied to 0.
  - READ waits indefinitely.

Decomposition:
- Package upt_seq_pkg holds:
  - the state encoding constants (3-bit);
  - the sample width constant SAMPLE_W=64.
- One sub-module, upt_seq_fifo: parameterised FWFT sync FIFO with push, pop, level, full and empty.
- The FSM, counters and watchdog stay in upt_seq_ctrl.

Test Plan:
- Bring-up timing: cfg_calib_cycles=10, start pulse.
  - core_rst high for 4 cycles after IDLE, then core_init high for exactly 1 cycle, then core_calib high for exactly 10 cycles, then core_en high.
- Calibration skip: cfg_calib_cycles=0, start.
  - core_calib is never asserted; core_en rises 1 cycle after core_init.
- Fill and stall: core model returns ready 3 cycles after read, with samples 0x1, 0x2, ...; no pops.
  - FIFO holds 0x1..0x4, fifo_level=4, FSM parked in RUN, core_read low.
  - Popping one entry yields exactly one more READ.
- Simultaneous push and pop at full: level=4, pop coinciding with a capture.
  - Level stays 4, head order is preserved, no entry is lost.
- Stop mid-READ: stop asserted while core_read=1.
  - Next cycle state_o=0, core_rst=1, core_read=0; FIFO contents are unchanged.
- Watchdog, with UPT_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: core_ready held 0.
  - After 16 READ cycles timeout_err=1, state_o=1 (RESET), no FIFO write.
